// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin register-write arbiter.
//   clog2  : index width for a requester count, never less than 1
//   onehot : one-hot vector with bit idx set (zero if idx is out of range)
package reg_arb_pkg;

    localparam int unsigned DefNReq  = 4;
    localparam int unsigned DefWidth = 8;
    localparam int unsigned MaxReq   = 32;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic logic [MaxReq-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MaxReq-1:0] r;
        r = '0;
        if (idx < n) begin
            r = MaxReq'(1) << idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bus between the requesting FSMs (master) and the arbiter (slave).
//   hold  : freeze arbitration
//   req   : one request bit per writer
//   wdata : packed write lanes, lane i = wdata[i*WIDTH +: WIDTH]
//   gnt   : one-hot, one-cycle acknowledge
//   q     : shared register contents
//   owner : index of the last writer
//   valid : set once any write has happened since reset
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned WIDTH = DefWidth
);
    localparam int unsigned OwnerW = clog2(N_REQ);

    logic                     hold;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*WIDTH-1:0]   wdata;
    logic [N_REQ-1:0]         gnt;
    logic [WIDTH-1:0]         q;
    logic [OwnerW-1:0]        owner;
    logic                     valid;

    modport master (
        output hold, req, wdata,
        input  gnt, q, owner, valid
    );

    modport slave (
        input  hold, req, wdata,
        output gnt, q, owner, valid
    );

endinterface

// File: rtl/reg_arst_en.sv
// WIDTH-bit register with load enable and asynchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears q to 0
//   ena   : load d on the next rising edge
//   d     : next value
//   q     : register contents
module reg_arst_en #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (ena) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register between N_REQ writers.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of reg_write_arbiter_if (hold/req/wdata in, gnt/q/owner/valid out)
// The winner's lane loads into the shared register on the same edge that raises gnt.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned WIDTH = DefWidth
) (
    input logic                clk,
    input logic                rst_n,
    reg_write_arbiter_if.slave bus
);

    localparam int unsigned OwnerW = clog2(N_REQ);

    logic [N_REQ-1:0]  r_gnt;
    logic [OwnerW-1:0] r_owner;
    logic [OwnerW-1:0] r_prio;
    logic              r_valid;

    logic [N_REQ-1:0]  w_elig;
    logic              w_found;
    logic [OwnerW-1:0] w_win;
    logic [WIDTH-1:0]  w_lane;
    logic              w_grant;
    logic [MaxReq-1:0] w_oh;
    logic [N_REQ-1:0]  w_gnt_next;
    logic [OwnerW-1:0] w_prio_next;

    // A requester acked this cycle still has req high; masking it avoids a double grant.
    assign w_elig = bus.req & ~r_gnt;

    // Scan from prio upward with an explicit wrap so non-power-of-two counts work.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_lane  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            int unsigned idx;
            idx = 32'(r_prio) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_win   = OwnerW'(idx);
                w_lane  = bus.wdata[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_grant     = w_found && !bus.hold;
        w_oh        = onehot(32'(w_win), N_REQ);
        w_gnt_next  = w_grant ? w_oh[N_REQ-1:0] : '0;
        w_prio_next = (32'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= '0;
            r_owner <= '0;
            r_prio  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_gnt <= w_gnt_next;
            if (w_grant) begin
                r_owner <= w_win;
                r_prio  <= w_prio_next;
                r_valid <= 1'b1;
            end
        end
    end

    reg_arst_en #(
        .WIDTH (WIDTH)
    ) u_shared_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (|w_gnt_next),
        .d     (w_lane),
        .q     (bus.q)
    );

    assign bus.gnt   = r_gnt;
    assign bus.owner = r_owner;
    assign bus.valid = r_valid;

endmodule
